gpio_bank_apb_irq: RTL and testbench
====================================

GPIO_BANK_APB_IRQ -- requirements
Module: gpio_bank_apb_irq

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, APB data bus width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, APB address width.
REQ-003 SHALL provide parameter NPINS, default 8, GPIO pin count, legal range 1..DATA_WIDTH.
REQ-004 SHALL provide parameter WAIT_STATES, default 1, ACCESS-phase wait cycles before pready, legal range 0..15.
REQ-005 Ports SHALL be as follows; one clock, asynchronous active-low reset:
- pclk  in  1  clock, all state on rising edge
- presetn  in  1  asynchronous active-low reset
- paddr  in  ADDR_WIDTH  register byte address
- pwrite  in  1  1=write, 0=read
- pselx  in  1  slave select
- penable  in  1  APB access phase
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, valid while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error, valid while pready=1
- y  in  NPINS  asynchronous pad inputs
- oe, pu, pd, a  out  NPINS  output enable, pull-up, pull-down, output data
- irq  out  1  level interrupt

Function
REQ-006 Register map SHALL be: 0x00 OE, 0x01 PU, 0x02 PD, 0x03 A, 0x04 Y (RO), 0x05 RISE_EN, 0x06 FALL_EN, 0x07 ISTAT (read, write-1-to-clear); bits above NPINS read 0 and ignore writes.
REQ-007 APB FSM SHALL have states IDLE, SETUP, ACCESS: IDLE->SETUP on pselx&!penable; SETUP->ACCESS on pselx&penable; ACCESS->IDLE one cycle after pready pulse.
REQ-008 In ACCESS a wait counter SHALL count WAIT_STATES cycles, then assert pready for exactly one cycle; WAIT_STATES=0 gives pready in the first ACCESS cycle.
REQ-009 Register write SHALL occur on the pready cycle only; prdata SHALL be registered and stable from pready cycle until next transfer.
REQ-010 pslverr SHALL assert with pready for unmapped address or write to 0x04; such writes SHALL change no state; errored reads return 0.
REQ-011 y SHALL pass through a 2-flop synchronizer; Y read returns synchronized value (2-cycle latency).
REQ-012 A third flop SHALL hold previous synced value; rising edge on bit i with RISE_EN[i]=1, or falling with FALL_EN[i]=1, SHALL set ISTAT[i] next cycle.
REQ-013 ISTAT write clears bits written as 1; if set and clear coincide on a bit, set SHALL win.
REQ-014 irq SHALL be registered OR of ISTAT, one cycle after ISTAT change.
REQ-015 pu output SHALL be PU & ~PD (pull-down wins on conflict); oe, pd, a SHALL drive registers directly.
REQ-016 pselx deassert during SETUP/ACCESS SHALL return FSM to IDLE without register update or pready.

Reset
REQ-017 presetn low SHALL immediately clear all registers, synchronizer flops, wait counter, prdata, pready, pslverr, irq to 0 and FSM to IDLE, including mid-transfer.
REQ-018 After presetn rises, first edge detection SHALL not occur until synchronizer has filled (no spurious edge from reset value).

Configuration
REQ-019 Macro GPIO_BANK_APB_IRQ_EN defined: REQ-012..014 and registers 0x05-0x07 present.
REQ-020 Macro undefined: no edge/interrupt logic; 0x05-0x07 unmapped (pslverr); irq tied 0.

Verification
REQ-021 Write 0x5A to 0x00 then read 0x00 -> oe=0x5A, prdata=0x5A, pslverr=0, pready after exactly WAIT_STATES ACCESS cycles.
REQ-022 Sweep y 0x00..0xFF, read 0x04 after 3 cycles each -> prdata equals y every step.
REQ-023 RISE_EN=0x01, y[0] 0->1 -> ISTAT=0x01, irq=1; write 0x01 to 0x07 -> ISTAT=0, irq=0 next cycle; repeat with edge same cycle as clear -> ISTAT stays 0x01.
REQ-024 Read 0x08 and write 0x04 -> pslverr=1 with pready, no register change, prdata=0.
REQ-025 PU=0xFF, PD=0x0F -> pu=0xF0, pd=0x0F.
REQ-026 Assert presetn low in ACCESS of write 0x33 to 0x03 -> a=0, pready=0, FSM IDLE; next transfer completes normally.

Source files
------------

// File: rtl/gpio_bank_apb_irq.sv
// ---------------------------------------------------------------------------
// gpio_bank_apb_irq
//
// APB-attached bank of NPINS general-purpose I/O pins. Software controls the
// pad output enable, pulls and output data through a small byte-addressed
// register file, and reads back the synchronized pad inputs. When the macro
// GPIO_BANK_APB_IRQ_EN is defined, per-pin rising/falling edge detection feeds
// a sticky write-1-to-clear status register and a level interrupt. Without
// the macro the edge/interrupt logic is absent, its registers decode as
// unmapped and irq is tied low.
//
// Register map (byte addresses):
//   0x00 OE       output enable
//   0x01 PU       pull-up request (pull-down wins on conflict)
//   0x02 PD       pull-down
//   0x03 A        output data
//   0x04 Y        synchronized pad inputs, read-only
//   0x05 RISE_EN  rising-edge interrupt enable    (GPIO_BANK_APB_IRQ_EN)
//   0x06 FALL_EN  falling-edge interrupt enable   (GPIO_BANK_APB_IRQ_EN)
//   0x07 ISTAT    interrupt status, W1C           (GPIO_BANK_APB_IRQ_EN)
//
// Ports:
//   pclk, presetn          clock, asynchronous active-low reset
//   paddr, pwrite, pselx,
//   penable, pwdata        APB request
//   prdata, pready,
//   pslverr                APB response (registered)
//   y                      asynchronous pad inputs
//   oe, pu, pd, a          pad controls
//   irq                    level interrupt, registered OR of ISTAT
// ---------------------------------------------------------------------------
module gpio_bank_apb_irq #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NPINS       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [NPINS-1:0]      y,
  output logic [NPINS-1:0]      oe,
  output logic [NPINS-1:0]      pu,
  output logic [NPINS-1:0]      pd,
  output logic [NPINS-1:0]      a,
  output logic                  irq
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_OE      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PU      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PD      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_A       = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_Y       = ADDR_WIDTH'(4);
`ifdef GPIO_BANK_APB_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_RISE_EN = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FALL_EN = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ISTAT   = ADDR_WIDTH'(7);
`endif

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  apb_state_e state_q, state_d;

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [NPINS-1:0] oe_q, oe_d;
  logic [NPINS-1:0] pu_q, pu_d;
  logic [NPINS-1:0] pd_q, pd_d;
  logic [NPINS-1:0] a_q, a_d;

  logic [NPINS-1:0] y_s1_q, y_s2_q;

  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  load_resp;
  logic                  wr_en;

`ifdef GPIO_BANK_APB_IRQ_EN
  logic [NPINS-1:0] y_s3_q;
  logic [NPINS-1:0] rise_en_q, rise_en_d;
  logic [NPINS-1:0] fall_en_q, fall_en_d;
  logic [NPINS-1:0] istat_q, istat_d;
  logic [NPINS-1:0] edge_set;
  logic [NPINS-1:0] istat_clr;
  logic [1:0]       fill_q, fill_d;
  logic             irq_q, irq_d;
`endif

  // Address decode: read data for the current address, plus the error flag
  // for unmapped addresses and writes to the read-only input register.
  always_comb begin
    rd_word = '0;
    acc_err = 1'b0;
    case (paddr)
      ADDR_OE: rd_word[NPINS-1:0] = oe_q;
      ADDR_PU: rd_word[NPINS-1:0] = pu_q;
      ADDR_PD: rd_word[NPINS-1:0] = pd_q;
      ADDR_A:  rd_word[NPINS-1:0] = a_q;
      ADDR_Y: begin
        rd_word[NPINS-1:0] = y_s2_q;
        acc_err            = pwrite;
      end
`ifdef GPIO_BANK_APB_IRQ_EN
      ADDR_RISE_EN: rd_word[NPINS-1:0] = rise_en_q;
      ADDR_FALL_EN: rd_word[NPINS-1:0] = fall_en_q;
      ADDR_ISTAT:   rd_word[NPINS-1:0] = istat_q;
`endif
      default: acc_err = 1'b1;
    endcase
  end

  // APB slave FSM. The response (pready, pslverr, prdata) is registered, so
  // it is loaded on the edge that enters the pready cycle: the SETUP->ACCESS
  // edge when there are no wait states, otherwise the edge after the last
  // wait cycle. The register write itself happens on the edge that ends the
  // pready cycle, which is also where the FSM returns to IDLE. Dropping pselx
  // at any point abandons the transfer with no write.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;
    load_resp  = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pselx && !penable) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!pselx) begin
          state_d = ST_IDLE;
        end else if (penable) begin
          state_d    = ST_ACCESS;
          wait_cnt_d = '0;
          load_resp  = (WAIT_STATES == 0);
        end
      end
      ST_ACCESS: begin
        if (!pselx) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (pready_q) begin
          wr_en      = pwrite && !acc_err;
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          load_resp  = ((wait_cnt_q + 4'd1) == WAIT_LAST);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    // Errored transfers return zero; writes leave the last read data alone.
    if (load_resp) begin
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      if (acc_err) begin
        prdata_d = '0;
      end else if (!pwrite) begin
        prdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
    end
  end

  // Pad control register writes; wr_en already excludes errored accesses.
  always_comb begin
    oe_d = oe_q;
    pu_d = pu_q;
    pd_d = pd_q;
    a_d  = a_q;
    if (wr_en) begin
      case (paddr)
        ADDR_OE: oe_d = pwdata[NPINS-1:0];
        ADDR_PU: pu_d = pwdata[NPINS-1:0];
        ADDR_PD: pd_d = pwdata[NPINS-1:0];
        ADDR_A:  a_d  = pwdata[NPINS-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      oe_q <= '0;
      pu_q <= '0;
      pd_q <= '0;
      a_q  <= '0;
    end else begin
      oe_q <= oe_d;
      pu_q <= pu_d;
      pd_q <= pd_d;
      a_q  <= a_d;
    end
  end

  // Two-flop synchronizer for the asynchronous pad inputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      y_s1_q <= '0;
      y_s2_q <= '0;
    end else begin
      y_s1_q <= y;
      y_s2_q <= y_s1_q;
    end
  end

`ifdef GPIO_BANK_APB_IRQ_EN
  // Edge detection compares the synchronized value with its one-cycle-old
  // copy. fill_q holds detection off until three real samples have passed
  // through the chain, so a pin sitting high at reset release is not seen as
  // a rising edge against the zero reset value. A set on the same cycle as a
  // software clear wins so no edge is lost.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    istat_clr = '0;
    if (wr_en) begin
      case (paddr)
        ADDR_RISE_EN: rise_en_d = pwdata[NPINS-1:0];
        ADDR_FALL_EN: fall_en_d = pwdata[NPINS-1:0];
        ADDR_ISTAT:   istat_clr = pwdata[NPINS-1:0];
        default: ;
      endcase
    end

    fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;

    edge_set = '0;
    if (fill_q == 2'd3) begin
      edge_set = (y_s2_q & ~y_s3_q & rise_en_q) |
                 (~y_s2_q & y_s3_q & fall_en_q);
    end

    istat_d = (istat_q & ~istat_clr) | edge_set;
    irq_d   = |istat_q;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      y_s3_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      istat_q   <= '0;
      fill_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      y_s3_q    <= y_s2_q;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      istat_q   <= istat_d;
      fill_q    <= fill_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign oe      = oe_q;
  assign pd      = pd_q;
  assign a       = a_q;
  // Pull-down takes priority so both pulls are never enabled together.
  assign pu      = pu_q & ~pd_q;

endmodule

// File: tb/tb_gpio_bank_apb_irq.sv
// ---------------------------------------------------------------------------
// tb_gpio_bank_apb_irq
//
// Directed testbench for gpio_bank_apb_irq with default parameters
// (8-bit bus, 8 pins, one wait state). Each test task drives its own APB
// traffic and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_gpio_bank_apb_irq;

  logic       pclk;
  logic       presetn;
  logic [7:0] paddr;
  logic       pwrite;
  logic       pselx;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] y_in;
  logic [7:0] oe;
  logic [7:0] pu;
  logic [7:0] pd;
  logic [7:0] a;
  logic       irq;

  int checks = 0;
  int errors = 0;

  gpio_bank_apb_irq #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .NPINS      (8),
    .WAIT_STATES(1)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pselx  (pselx),
    .penable(penable),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .y      (y_in),
    .oe     (oe),
    .pu     (pu),
    .pd     (pd),
    .a      (a),
    .irq    (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One full APB transfer, entered and left at 1 time unit after a rising
  // edge. waits is the number of ACCESS cycles seen before pready. With
  // toggle_y0 set, y[0] rises together with penable so its edge lands on the
  // same clock as the register write.
  task automatic apb_xfer(input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit toggle_y0,
                          output logic [7:0] rdata, output logic err,
                          output int waits);
    int  edges;
    bit  got;
    rdata   = '0;
    err     = 1'b0;
    edges   = 0;
    got     = 1'b0;
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (toggle_y0) y_in[0] = 1'b1;
    while (!got && edges < 40) begin
      @(posedge pclk); #1;
      edges++;
      if (pready === 1'b1) begin
        got   = 1'b1;
        rdata = prdata;
        err   = pslverr;
      end
    end
    waits = edges - 1;
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL pready_timeout addr=%h: saw no pready, required pready within 40 cycles", addr);
    end
    @(posedge pclk); #1;
    pselx   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    pselx   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    y_in    = '0;
    #12;
    checks++;
    if ({oe, pu, pd, a} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_pads: got %h required 00000000", {oe, pu, pd, a});
    end
    checks++;
    if ({pready, pslverr, irq, prdata} !== 11'h0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got %h required 000", {pready, pslverr, irq, prdata});
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    logic       err;
    int         w;
    apb_xfer(1'b1, 8'h00, 8'h5A, 1'b0, rd, err, w);
    checks++;
    if (w !== 1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_oe_resp: waits=%0d err=%b required waits=1 err=0", w, err);
    end
    checks++;
    if (oe !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL wr_oe_pin: got %h required 5a", oe);
    end
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pready_pulse: got %b required 0", pready);
    end
    apb_xfer(1'b0, 8'h00, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h5A || err !== 1'b0 || w !== 1) begin
      errors++;
      $display("[TB] FAIL rd_oe: got %h err=%b waits=%0d required 5a err=0 waits=1", rd, err, w);
    end
    @(posedge pclk); #1;
    checks++;
    if (prdata !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL prdata_hold: got %h required 5a", prdata);
    end
  endtask

  task automatic test_pulls();
    logic [7:0] rd;
    logic       err;
    int         w;
    apb_xfer(1'b1, 8'h01, 8'hFF, 1'b0, rd, err, w);
    apb_xfer(1'b1, 8'h02, 8'h0F, 1'b0, rd, err, w);
    checks++;
    if (pu !== 8'hF0 || pd !== 8'h0F) begin
      errors++;
      $display("[TB] FAIL pull_conflict: pu=%h pd=%h required pu=f0 pd=0f", pu, pd);
    end
    apb_xfer(1'b0, 8'h01, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL rd_pu_reg: got %h required ff", rd);
    end
  endtask

  task automatic test_abort();
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h00;
    pwdata  = 8'hAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    pselx   = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      checks++;
      if (pready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_pready cycle %0d: got %b required 0", i, pready);
      end
    end
    checks++;
    if (oe !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL abort_no_write: got %h required 5a", oe);
    end
  endtask

  task automatic test_errors();
    logic [7:0] rd;
    logic       err;
    int         w;
    apb_xfer(1'b0, 8'h08, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL err_rd_unmapped: err=%b data=%h required err=1 data=00", err, rd);
    end
    apb_xfer(1'b1, 8'h04, 8'h77, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL err_wr_ro: err=%b data=%h required err=1 data=00", err, rd);
    end
    checks++;
    if ({oe, pu, pd, a} !== {8'h5A, 8'hF0, 8'h0F, 8'h00}) begin
      errors++;
      $display("[TB] FAIL err_no_change: got %h required 5af00f00", {oe, pu, pd, a});
    end
    apb_xfer(1'b1, 8'h10, 8'h77, 1'b0, rd, err, w);
    checks++;
    if (err !== 1'b1 || {oe, pu, pd, a} !== {8'h5A, 8'hF0, 8'h0F, 8'h00}) begin
      errors++;
      $display("[TB] FAIL err_wr_unmapped: err=%b regs=%h required err=1 regs=5af00f00", err, {oe, pu, pd, a});
    end
  endtask

  task automatic test_y_sweep();
    logic [7:0] rd;
    logic       err;
    int         w;
    for (int v = 0; v < 256; v++) begin
      y_in = 8'(v);
      repeat (3) @(posedge pclk);
      #1;
      apb_xfer(1'b0, 8'h04, 8'h00, 1'b0, rd, err, w);
      checks++;
      if (rd !== 8'(v) || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL y_sweep %h: got %h err=%b required %h err=0", 8'(v), rd, err, 8'(v));
      end
    end
    y_in = 8'h00;
    repeat (4) @(posedge pclk);
    #1;
  endtask

`ifdef GPIO_BANK_APB_IRQ_EN
  task automatic test_irq();
    logic [7:0] rd;
    logic       err;
    int         w;
    apb_xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL istat_idle: istat=%h irq=%b required 00 0", rd, irq);
    end
    apb_xfer(1'b1, 8'h05, 8'h01, 1'b0, rd, err, w);
    y_in = 8'h01;
    repeat (5) @(posedge pclk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_rise: got %b required 1", irq);
    end
    apb_xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h01 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL istat_rise: got %h err=%b required 01 err=0", rd, err);
    end
    apb_xfer(1'b1, 8'h07, 8'h01, 1'b0, rd, err, w);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_lag: got %b required 1", irq);
    end
    @(posedge pclk); #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_clear: got %b required 0", irq);
    end
    apb_xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("[TB] FAIL istat_clear: got %h required 00", rd);
    end
    // Rising edge on the same clock as the clear: set must win.
    y_in = 8'h00;
    repeat (4) @(posedge pclk);
    #1;
    apb_xfer(1'b1, 8'h07, 8'h01, 1'b1, rd, err, w);
    apb_xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h01 || irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_wins: istat=%h irq=%b required 01 1", rd, irq);
    end
    // Falling edge on pin 1.
    apb_xfer(1'b1, 8'h06, 8'h02, 1'b0, rd, err, w);
    y_in = 8'h03;
    repeat (4) @(posedge pclk);
    #1;
    y_in = 8'h01;
    repeat (5) @(posedge pclk);
    #1;
    apb_xfer(1'b0, 8'h07, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h03) begin
      errors++;
      $display("[TB] FAIL istat_fall: got %h required 03", rd);
    end
    apb_xfer(1'b1, 8'h07, 8'hFF, 1'b0, rd, err, w);
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_clear_all: got %b required 0", irq);
    end
  endtask
`else
  task automatic test_irq();
    logic [7:0] rd;
    logic       err;
    int         w;
    for (int i = 5; i < 8; i++) begin
      apb_xfer(1'b0, 8'(i), 8'h00, 1'b0, rd, err, w);
      checks++;
      if (err !== 1'b1 || rd !== 8'h00) begin
        errors++;
        $display("[TB] FAIL irq_regs_unmapped %0d: err=%b data=%h required err=1 data=00", i, err, rd);
      end
    end
    y_in = 8'hFF;
    repeat (5) @(posedge pclk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_tied_low: got %b required 0", irq);
    end
    y_in = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic       err;
    int         w;
    apb_xfer(1'b1, 8'h03, 8'hA5, 1'b0, rd, err, w);
    apb_xfer(1'b0, 8'h03, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'hA5 || w !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_rd_a: got %h waits=%0d required a5 waits=1", rd, w);
    end
    apb_xfer(1'b0, 8'h02, 8'h00, 1'b0, rd, err, w);
    checks++;
    if (rd !== 8'h0F || a !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL b2b_rd_pd: got %h a=%h required 0f a=a5", rd, a);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd;
    logic       err;
    int         w;
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h03;
    pwdata  = 8'h33;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #2;
    checks++;
    if (a !== 8'h00 || pready !== 1'b0 || oe !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid: a=%h pready=%b oe=%h required 00 0 00", a, pready, oe);
    end
    pselx   = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (a !== 8'h00 || pready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold: a=%h pready=%b required 00 0", a, pready);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1'b1, 8'h03, 8'h12, 1'b0, rd, err, w);
    checks++;
    if (a !== 8'h12 || err !== 1'b0 || w !== 1) begin
      errors++;
      $display("[TB] FAIL after_reset_xfer: a=%h err=%b waits=%0d required 12 0 1", a, err, w);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_pulls();
    test_abort();
    test_errors();
    test_y_sweep();
    test_irq();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
